out_merge_rr: RTL and testbench



---
 rtl/psys_route_pkg.sv | 33 +++
 rtl/axis_skid_buf.sv | 68 ++++++
 rtl/out_merge_rr.sv | 115 +++++++++++
 tb/tb_out_merge_rr.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psys_route_pkg.sv
// Shared routing constants and the rotating first-one search used by the
// poly_systolic output merge.
package psys_route_pkg;

  localparam int unsigned MODE_RR  = 0;
  localparam int unsigned MODE_OR  = 1;
  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned CH_IDX_W = 4;

  typedef struct packed {
    logic                found;
    logic [CH_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning start, start+1, ... modulo n (n <= MAX_CH).
  function automatic rr_pick_t rr_first_one(input logic [MAX_CH-1:0]   req,
                                            input logic [CH_IDX_W-1:0] start,
                                            input int unsigned         n);
    rr_pick_t    pick;
    int unsigned k;
    pick = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      k = 32'(start) + i;
      if (k >= n) k = k - n;
      if ((i < n) && !pick.found && req[k[CH_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = k[CH_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered AXI-Stream buffer; entry 0 always drives the output,
// input ready is the registered "not full".
module axis_skid_buf #(
  parameter int unsigned DWIDTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  input  logic [DWIDTH-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  logic [1:0]      cnt_q, cnt_d;
  logic [DWIDTH:0] e0_q, e0_d, e1_q, e1_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;
  logic            push, pop;

  assign push = s_valid_i & rdy_q;
  assign pop  = vld_q & m_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (push && !pop) begin
      if (cnt_q == 2'd0) e0_d = {s_last_i, s_data_i};
      else               e1_d = {s_last_i, s_data_i};
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      e0_d  = e1_q;
      cnt_d = cnt_q - 2'd1;
    end else if (push && pop) begin
      // Only reachable with one entry held: replace it in place.
      e0_d = {s_last_i, s_data_i};
    end
    rdy_d = (cnt_d != 2'd2);
    vld_d = (cnt_d != 2'd0);
  end

  // Ready resets high so the first cycle out of reset can accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
    end
  end

  assign s_ready_o = rdy_q;
  assign m_valid_o = vld_q;
  assign m_data_o  = e0_q[DWIDTH-1:0];
  assign m_last_o  = e0_q[DWIDTH];

endmodule

// File: rtl/out_merge_rr.sv
// N-channel AXI-Stream merge: packet-locked round-robin or legacy OR-merge,
// followed by a two-entry skid stage.
module out_merge_rr
  import psys_route_pkg::*;
#(
  parameter int unsigned DWIDTH = 128,
  parameter int unsigned NCH    = 4,
  parameter int unsigned MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH*DWIDTH-1:0]   s_axis_tdata,
  input  logic [NCH-1:0]          s_axis_tvalid,
  input  logic [NCH-1:0]          s_axis_tlast,
  output logic [NCH-1:0]          s_axis_tready,
  output logic [DWIDTH-1:0]       m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(NCH)-1:0]  grant,
  output logic                    locked,
  output logic                    collision
);

  localparam int unsigned   GW      = $clog2(NCH);
  localparam logic [GW-1:0] LAST_CH = GW'(NCH - 1);

  logic              in_ready;
  logic              sel_valid, sel_last, accept, multi;
  logic [DWIDTH-1:0] sel_data;
  logic [GW-1:0]     winner;
  rr_pick_t          pick;

  logic [GW-1:0]     ptr_q, ptr_d, grant_q, grant_d;
  logic              locked_q, locked_d, coll_q, coll_d;

  // Source selection and per-channel ready; combinational on tvalid only.
  always_comb begin
    pick          = rr_first_one(MAX_CH'(s_axis_tvalid), CH_IDX_W'(ptr_q), NCH);
    winner        = '0;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    s_axis_tready = '0;
    if (MODE == MODE_OR) begin
      sel_valid = |s_axis_tvalid;
      for (int k = 0; k < NCH; k++) begin
        if (s_axis_tvalid[k]) begin
          sel_data = sel_data | s_axis_tdata[k*DWIDTH +: DWIDTH];
          sel_last = sel_last | s_axis_tlast[k];
        end
      end
      s_axis_tready = {NCH{in_ready & rst_n}};
    end else begin
      winner    = locked_q ? grant_q : GW'(pick.idx);
      sel_valid = locked_q ? s_axis_tvalid[winner] : pick.found;
      sel_data  = s_axis_tdata[winner*DWIDTH +: DWIDTH];
      sel_last  = s_axis_tlast[winner];
      if (in_ready && rst_n && (locked_q || pick.found))
        s_axis_tready[winner] = 1'b1;
    end
  end

  assign accept = in_ready & sel_valid;
  assign multi  = |(s_axis_tvalid & (s_axis_tvalid - NCH'(1)));

  // Lock / pointer / collision bookkeeping on accepted beats.
  always_comb begin
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    locked_d = locked_q;
    coll_d   = coll_q;
    if (accept) begin
      if (MODE == MODE_OR) begin
        if (multi) coll_d = 1'b1;
      end else begin
        grant_d  = winner;
        locked_d = !sel_last;
        if (sel_last) ptr_d = (winner == LAST_CH) ? '0 : winner + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      grant_q  <= '0;
      locked_q <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      locked_q <= locked_d;
      coll_q   <= coll_d;
    end
  end

  axis_skid_buf #(.DWIDTH(DWIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (sel_valid),
    .s_data_i  (sel_data),
    .s_last_i  (sel_last),
    .s_ready_o (in_ready),
    .m_valid_o (m_axis_tvalid),
    .m_data_o  (m_axis_tdata),
    .m_last_o  (m_axis_tlast),
    .m_ready_i (m_axis_tready)
  );

  assign grant     = grant_q;
  assign locked    = locked_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_out_merge_rr.sv
// Directed bench for out_merge_rr: one round-robin instance and one OR-merge
// instance sharing clock and reset.
module tb_out_merge_rr;

  localparam int unsigned DW = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned GW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] r_tdata, o_tdata;
  logic [NC-1:0]    r_tvalid, r_tlast, r_tready, o_tvalid, o_tlast, o_tready;
  logic [DW-1:0]    r_mdata, o_mdata;
  logic             r_mlast, r_mvalid, r_mready, o_mlast, o_mvalid, o_mready;
  logic [GW-1:0]    r_grant, o_grant;
  logic             r_locked, r_coll, o_locked, o_coll;

  out_merge_rr #(.DWIDTH(DW), .NCH(NC), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(r_tdata), .s_axis_tvalid(r_tvalid), .s_axis_tlast(r_tlast),
    .s_axis_tready(r_tready),
    .m_axis_tdata(r_mdata), .m_axis_tlast(r_mlast), .m_axis_tvalid(r_mvalid),
    .m_axis_tready(r_mready),
    .grant(r_grant), .locked(r_locked), .collision(r_coll)
  );

  out_merge_rr #(.DWIDTH(DW), .NCH(NC), .MODE(1)) u_or (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(o_tdata), .s_axis_tvalid(o_tvalid), .s_axis_tlast(o_tlast),
    .s_axis_tready(o_tready),
    .m_axis_tdata(o_mdata), .m_axis_tlast(o_mlast), .m_axis_tvalid(o_mvalid),
    .m_axis_tready(o_mready),
    .grant(o_grant), .locked(o_locked), .collision(o_coll)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-channel packet sources for the round-robin instance.
  int   pk_len[NC];
  int   pk_cnt[NC];
  int   beat[NC];
  int   seq[NC];
  logic hold[NC];
  logic [NC-1:0] hs;

  logic [DW-1:0] q_data[$];
  logic          q_last[$];
  int            q_cyc[$];
  int            cyc_n;

  task automatic clear_src();
    for (int c = 0; c < NC; c++) begin
      pk_len[c] = 0; pk_cnt[c] = 0; beat[c] = 0; seq[c] = 0; hold[c] = 1'b0;
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < NC; c++) begin
      r_tvalid[c]           = (pk_cnt[c] > 0) && !hold[c];
      r_tdata[c*DW +: DW]   = DW'(c*256 + seq[c]);
      r_tlast[c]            = (beat[c] == pk_len[c] - 1);
    end
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic tick();
    drive_src();
    #1;
    hs = r_tvalid & r_tready;
    if (r_mvalid && r_mready) begin
      q_data.push_back(r_mdata);
      q_last.push_back(r_mlast);
      q_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    for (int c = 0; c < NC; c++) begin
      if (hs[c]) begin
        seq[c]++;
        if (beat[c] == pk_len[c] - 1) begin
          beat[c] = 0;
          pk_cnt[c]--;
        end else begin
          beat[c]++;
        end
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    r_mready = 1'b0;
    clear_src();
    drive_src();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_data.delete(); q_last.delete(); q_cyc.delete();
    cyc_n = 0;
  endtask

  initial begin
    o_tvalid = '0; o_tdata = '0; o_tlast = '0; o_mready = 1'b1;
    r_mready = 1'b0;
    clear_src();
    drive_src();
    cyc_n = 0;
    @(negedge clk);
    #1;
    // Reset state
    chk("rst_tready", 32'(r_tready), 32'h0);
    chk("rst_mvalid", 32'(r_mvalid), 32'h0);
    chk("rst_grant",  32'(r_grant),  32'h0);
    chk("rst_locked", 32'(r_locked), 32'h0);
    chk("rst_or_rdy", 32'(o_tready), 32'h0);
    @(negedge clk);

    // Two simultaneous 3-beat packets on ch1 and ch3
    do_reset();
    r_mready = 1'b1;
    pk_len[1] = 3; pk_cnt[1] = 1;
    pk_len[3] = 3; pk_cnt[3] = 1;
    tick();
    chk("t1_locked", 32'(r_locked), 32'h1);
    chk("t1_grant",  32'(r_grant),  32'h1);
    repeat (7) tick();
    chk("t1_count", 32'(q_data.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_data%0d", i), 32'(q_data[i]), (i < 3) ? 32'h0100 + 32'(i) : 32'h0300 + 32'(i - 3));
      chk($sformatf("t1_last%0d", i), 32'(q_last[i]), (i == 2 || i == 5) ? 32'h1 : 32'h0);
      chk($sformatf("t1_cyc%0d", i),  32'(q_cyc[i]),  32'(i + 1));
    end
    chk("t1_unlock", 32'(r_locked), 32'h0);
    pk_len[0] = 1; pk_cnt[0] = 1;
    pk_len[3] = 1; pk_cnt[3] = 1;
    drive_src();
    #1;
    chk("t1_ptr0_rdy", 32'(r_tready), 32'b0001);
    repeat (3) tick();
    chk("t1_next_a", 32'(q_data[6]), 32'h0000);
    chk("t1_next_b", 32'(q_data[7]), 32'h0303);

    // Four channels of continuous single-beat packets
    do_reset();
    r_mready = 1'b1;
    for (int c = 0; c < NC; c++) begin pk_len[c] = 1; pk_cnt[c] = 2; end
    repeat (9) tick();
    chk("t2_count", 32'(q_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_ch%0d", i),  32'(q_data[i] >> 8), 32'(i % 4));
      chk($sformatf("t2_cyc%0d", i), 32'(q_cyc[i]),       32'(i + 1));
    end

    // ch2 locked and idle while ch0 waits
    do_reset();
    r_mready = 1'b1;
    pk_len[2] = 3; pk_cnt[2] = 1;
    tick();
    hold[2] = 1'b1;
    pk_len[0] = 1; pk_cnt[0] = 1;
    for (int s = 0; s < 5; s++) begin
      drive_src();
      #1;
      chk($sformatf("t3_rdy0_%0d", s),   32'(r_tready[0]), 32'h0);
      chk($sformatf("t3_locked_%0d", s), 32'(r_locked),    32'h1);
      tick();
    end
    hold[2] = 1'b0;
    repeat (4) tick();
    chk("t3_count", 32'(q_data.size()), 32'd4);
    chk("t3_d0", 32'(q_data[0]), 32'h0200);
    chk("t3_d1", 32'(q_data[1]), 32'h0201);
    chk("t3_d2", 32'(q_data[2]), 32'h0202);
    chk("t3_d3", 32'(q_data[3]), 32'h0000);

    // Back-pressure: downstream stalls for 4 cycles mid-stream
    do_reset();
    r_mready = 1'b1;
    pk_len[1] = 10; pk_cnt[1] = 1;
    repeat (3) tick();
    r_mready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      drive_src();
      #1;
      chk($sformatf("t4_rdy_%0d", s),  32'(r_tready[1]), (s == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t4_vld_%0d", s),  32'(r_mvalid),    32'h1);
      chk($sformatf("t4_hold_%0d", s), 32'(r_mdata),     32'h0102);
      tick();
    end
    r_mready = 1'b1;
    drive_src();
    #1;
    chk("t4_rdy_pop", 32'(r_tready[1]), 32'h0);
    tick();
    drive_src();
    #1;
    chk("t4_rdy_back", 32'(r_tready[1]), 32'h1);
    tick();
    repeat (7) tick();
    chk("t4_count", 32'(q_data.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_d%0d", i),   32'(q_data[i]), 32'h0100 + 32'(i));
      chk($sformatf("t4_cyc%0d", i), 32'(q_cyc[i]),  (i < 2) ? 32'(i + 1) : 32'(i + 5));
    end
    chk("t4_last8", 32'(q_last[8]), 32'h0);
    chk("t4_last9", 32'(q_last[9]), 32'h1);

    // OR-merge with collision
    o_mready = 1'b1;
    o_tvalid = 4'b0011;
    o_tdata  = {16'hFFFF, 16'hFFFF, 16'h0F00, 16'h00F0};
    o_tlast  = 4'b0000;
    #1;
    chk("t5_rdy",      32'(o_tready), 32'hF);
    chk("t5_coll_pre", 32'(o_coll),   32'h0);
    @(posedge clk); @(negedge clk);
    chk("t5_vld",    32'(o_mvalid), 32'h1);
    chk("t5_data",   32'(o_mdata),  32'h0FF0);
    chk("t5_last",   32'(o_mlast),  32'h0);
    chk("t5_coll",   32'(o_coll),   32'h1);
    chk("t5_grant",  32'(o_grant),  32'h0);
    chk("t5_locked", 32'(o_locked), 32'h0);
    o_tvalid = 4'b0100;
    o_tdata  = {16'hFFFF, 16'h1234, 16'h0F00, 16'h00F0};
    o_tlast  = 4'b1100;
    @(posedge clk); @(negedge clk);
    chk("t5_single",  32'(o_mdata), 32'h1234);
    chk("t5_slast",   32'(o_mlast), 32'h1);
    chk("t5_sticky1", 32'(o_coll),  32'h1);
    o_tvalid = 4'b0000;
    @(posedge clk); @(negedge clk);
    chk("t5_idle",    32'(o_mvalid), 32'h0);
    chk("t5_sticky2", 32'(o_coll),   32'h1);

    // Reset mid-packet with the skid full
    do_reset();
    r_mready = 1'b0;
    pk_len[1] = 10; pk_cnt[1] = 1;
    repeat (3) tick();
    drive_src();
    #1;
    chk("t6_full_rdy", 32'(r_tready[1]), 32'h0);
    chk("t6_locked",   32'(r_locked),    32'h1);
    chk("t6_vld",      32'(r_mvalid),    32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_r_tready", 32'(r_tready), 32'h0);
    chk("t6_r_mvalid", 32'(r_mvalid), 32'h0);
    chk("t6_r_mdata",  32'(r_mdata),  32'h0);
    chk("t6_r_mlast",  32'(r_mlast),  32'h0);
    chk("t6_r_grant",  32'(r_grant),  32'h0);
    chk("t6_r_locked", 32'(r_locked), 32'h0);
    chk("t6_o_coll",   32'(o_coll),   32'h0);
    chk("t6_o_tready", 32'(o_tready), 32'h0);
    @(negedge clk);
    clear_src();
    rst_n = 1'b1;
    q_data.delete(); q_last.delete(); q_cyc.delete();
    cyc_n = 0;
    r_mready = 1'b1;
    pk_len[1] = 2; pk_cnt[1] = 1;
    pk_len[3] = 1; pk_cnt[3] = 1;
    drive_src();
    #1;
    chk("t6_post_rdy", 32'(r_tready), 32'b0010);
    repeat (4) tick();
    chk("t6_count", 32'(q_data.size()), 32'd3);
    chk("t6_d0", 32'(q_data[0]), 32'h0100);
    chk("t6_d1", 32'(q_data[1]), 32'h0101);
    chk("t6_d2", 32'(q_data[2]), 32'h0300);
    chk("t6_cyc2", 32'(q_cyc[2]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
